// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared FSM state encoding and default sizes for the counter scheduler
package counter_sched_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_N_REQ = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; nearest valid request after ptr wins
//  req   in   N_REQ  request vector
//  ptr   in   ID_W   last granted id; search starts at ptr+1
//  grant out  N_REQ  one-hot grant, zero when no request
//  id    out  ID_W   encoded grant, zero when no request
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id
);

    logic [ID_W-1:0] k;

    // Walk from the farthest slot toward ptr+1 so the closest valid slot is the last one written.
    always_comb begin
        grant = '0;
        id    = '0;
        k     = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            k = ID_W'((int'(ptr) + off) % N_REQ);
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                id       = k;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one up/down modulo counter between requesters
//  clock           in   1            rising-edge clock
//  reset           in   1            asynchronous active-high reset
//  io_req_valid    in   N_REQ        per-requester job request
//  io_req_ready    out  N_REQ        one-hot grant (IDLE only)
//  io_req_limit    in   N_REQ*WIDTH  requester i limit at [i*WIDTH +: WIDTH]
//  io_req_dir      in   N_REQ        1 = count up, 0 = count down
//  io_abort        in   1            terminate the current job
//  io_done         out  1            one-cycle completion pulse
//  io_done_id      out  ID_W         owner of the completed job
//  io_done_aborted out  1            job ended through io_abort
//  io_busy         out  1            high in CLEAR/RUN/DONE
//  io_cnt_*        out/in            drive and observe the shared counter
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       io_req_valid,
    output logic [N_REQ-1:0]       io_req_ready,
    input  logic [N_REQ*WIDTH-1:0] io_req_limit,
    input  logic [N_REQ-1:0]       io_req_dir,
    input  logic                   io_abort,
    output logic                   io_done,
    output logic [ID_W-1:0]        io_done_id,
    output logic                   io_done_aborted,
    output logic                   io_busy,
    output logic [WIDTH-1:0]       io_cnt_din,
    output logic                   io_cnt_en,
    output logic                   io_cnt_mod,
    output logic                   io_cnt_dir,
    input  logic [WIDTH-1:0]       io_cnt_dout
);

    state_t          state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, job_id, gnt_id;
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] job_limit, target, sel_limit;
    logic             job_dir, aborted, hs, abort_hit;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req   (io_req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .id    (gnt_id)
    );

    assign io_req_ready = (state == S_IDLE && !reset) ? gnt : '0;
    assign hs           = |(io_req_valid & io_req_ready);
    assign sel_limit    = io_req_limit[int'(gnt_id)*WIDTH +: WIDTH];
    assign abort_hit    = io_abort && (state == S_CLEAR || state == S_RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Down jobs end at -limit because CLEAR always starts the count from 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= ID_W'(N_REQ - 1);
            job_id    <= '0;
            job_limit <= '0;
            job_dir   <= 1'b0;
            target    <= '0;
            aborted   <= 1'b0;
        end else if (hs) begin
            rr_ptr    <= gnt_id;
            job_id    <= gnt_id;
            job_limit <= sel_limit;
            job_dir   <= io_req_dir[gnt_id];
            target    <= io_req_dir[gnt_id] ? sel_limit : -sel_limit;
            aborted   <= 1'b0;
        end else if (abort_hit) begin
            aborted   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        io_cnt_en  = 1'b0;
        io_cnt_din = '0;
        io_cnt_mod = 1'b0;
        io_cnt_dir = 1'b0;
        case (state)
            S_IDLE:  state_nxt = hs ? S_CLEAR : S_IDLE;
            // Modulo-up with din equal to the current value wraps the counter to 0 in one step.
            S_CLEAR: begin
                if (io_abort) begin
                    state_nxt = S_DONE;
                end else begin
                    io_cnt_en  = 1'b1;
                    io_cnt_dir = 1'b1;
                    io_cnt_mod = 1'b1;
                    io_cnt_din = io_cnt_dout;
                    state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (io_abort || io_cnt_dout == target) begin
                    state_nxt = S_DONE;
                end else begin
                    io_cnt_en  = 1'b1;
                    io_cnt_dir = job_dir;
                    io_cnt_mod = job_dir;
                    io_cnt_din = job_limit;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign io_done         = state == S_DONE;
    assign io_done_id      = io_done ? job_id : '0;
    assign io_done_aborted = io_done && aborted;
    assign io_busy         = state != S_IDLE;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed checks of counter_sched driving a behavioural modulo counter
module tb_counter_sched;

    localparam int W = 10;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req_valid, req_ready, req_dir;
    logic [N*W-1:0] req_limit;
    logic         abort, done, done_aborted, busy;
    logic [1:0]   done_id;
    logic [W-1:0] cnt_din, cnt_dout;
    logic         cnt_en, cnt_mod, cnt_dir;

    int tests = 0;
    int fails = 0;

    counter_sched #(.WIDTH(W), .N_REQ(N)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_req_valid    (req_valid),
        .io_req_ready    (req_ready),
        .io_req_limit    (req_limit),
        .io_req_dir      (req_dir),
        .io_abort        (abort),
        .io_done         (done),
        .io_done_id      (done_id),
        .io_done_aborted (done_aborted),
        .io_busy         (busy),
        .io_cnt_din      (cnt_din),
        .io_cnt_en       (cnt_en),
        .io_cnt_mod      (cnt_mod),
        .io_cnt_dir      (cnt_dir),
        .io_cnt_dout     (cnt_dout)
    );

    always #5 clock = ~clock;

    // The shared counter datapath the scheduler sits in front of.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_dout <= '0;
        else if (cnt_en)
            cnt_dout <= cnt_dir ? ((cnt_mod && cnt_dout == cnt_din) ? '0 : cnt_dout + 10'd1)
                                : cnt_dout - 10'd1;
    end

    typedef struct {
        int         id;
        logic [9:0] lim;
        logic       dir;
        int         lat;
        logic [9:0] fin;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Latency n counts cycles from the handshake cycle (n=0); done expected at n = limit+3.
    task automatic run_job(input int id, input logic [9:0] lim, input logic dir,
                           input int exp_lat, input logic [9:0] fin);
        int         lat;
        logic [9:0] expv, bad_act, bad_exp;
        bit         trace_ok;
        lat      = -1;
        trace_ok = 1'b1;
        bad_act  = '0;
        bad_exp  = '0;
        @(negedge clock);
        req_valid              = '0;
        req_valid[id]          = 1'b1;
        req_limit[id*W +: W]   = lim;
        req_dir[id]            = dir;
        #1 chk("grant", 32'(req_ready), 32'(1) << id);
        @(negedge clock);
        req_valid            = '0;
        req_limit[id*W +: W] = ~lim;
        req_dir[id]          = ~dir;
        for (int n = 1; n <= exp_lat + 20; n++) begin
            if (n >= 2 && n <= int'(lim) + 2) begin
                expv = dir ? 10'(n - 2) : 10'(2 - n);
                if (cnt_dout !== expv && trace_ok) begin
                    trace_ok = 1'b0;
                    bad_act  = cnt_dout;
                    bad_exp  = expv;
                end
            end
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clock);
        end
        chk("latency", lat, exp_lat);
        chk("done_id", 32'(done_id), id);
        chk("done_aborted", 32'(done_aborted), 0);
        chk("final_dout", 32'(cnt_dout), 32'(fin));
        tests++;
        if (!trace_ok) begin
            fails++;
            $display("FAIL trace: got %0h expected %0h", bad_act, bad_exp);
        end
        @(negedge clock);
        chk("idle_after_done", {done, busy, cnt_en}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         grants[$];
        int         gcnt, seen;
        bit         onehot_ok;
        int         exp_order[5];
        vecs[0] = '{0, 10'd5,    1'b1, 8,   10'd5};
        vecs[1] = '{2, 10'd3,    1'b0, 6,   10'h3FD};
        vecs[2] = '{1, 10'h1A7,  1'b1, 426, 10'h1A7};
        vecs[3] = '{3, 10'd0,    1'b1, 3,   10'd0};
        vecs[4] = '{1, 10'd2,    1'b0, 5,   10'h3FE};
        vecs[5] = '{0, 10'd0,    1'b0, 3,   10'd0};
        exp_order = '{0, 1, 2, 3, 0};
        req_valid = '1;
        req_limit = '0;
        req_dir   = '0;
        abort     = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_ready", 32'(req_ready), 0);
        chk("reset_outs", {done, done_aborted, busy, cnt_en}, 0);
        chk("reset_dout", 32'(cnt_dout), 0);
        reset     = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 6; i++)
            run_job(vecs[i].id, vecs[i].lim, vecs[i].dir, vecs[i].lat, vecs[i].fin);

        // Reset while a job is counting: no done pulse, everything idle, next job clean.
        @(negedge clock);
        req_valid[2]         = 1'b1;
        req_limit[2*W +: W]  = 10'd20;
        req_dir[2]           = 1'b1;
        @(negedge clock);
        req_valid = '0;
        for (int i = 0; i < 40 && cnt_dout != 10'd7; i++) @(negedge clock);
        chk("reach_7", 32'(cnt_dout), 7);
        reset        = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        chk("mid_reset_ready", 32'(req_ready), 0);
        chk("mid_reset_outs", {done, busy, cnt_en}, 0);
        chk("mid_reset_dout", 32'(cnt_dout), 0);
        @(negedge clock);
        reset     = 1'b0;
        req_valid = '0;
        seen      = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        run_job(3, 10'd2, 1'b1, 5, 10'd2);

        // Fairness: all four requesting continuously, pointer last at 3.
        @(negedge clock);
        req_valid = '1;
        req_limit = {4{10'd1}};
        req_dir   = '1;
        onehot_ok = 1'b1;
        for (int i = 0; i < 100 && grants.size() < 5; i++) begin
            #1;
            if (|req_ready) begin
                if (!$onehot(req_ready)) onehot_ok = 1'b0;
                grants.push_back($clog2(req_ready));
            end
            @(negedge clock);
        end
        req_valid = '0;
        gcnt = grants.size();
        chk("grant_count", gcnt, 5);
        tests++;
        if (!onehot_ok) begin
            fails++;
            $display("FAIL grant_onehot: got non-one-hot ready, required one-hot");
        end
        for (int i = 0; i < 5 && i < gcnt; i++)
            chk($sformatf("grant_order_%0d", i), grants[i], exp_order[i]);
        for (int i = 0; i < 20 && busy; i++) @(negedge clock);
        chk("fair_drain", 32'(busy), 0);

        // Abort at dout=40 of a limit-100 job.
        @(negedge clock);
        req_valid[0]       = 1'b1;
        req_limit[0 +: W]  = 10'd100;
        req_dir[0]         = 1'b1;
        @(negedge clock);
        req_valid = '0;
        for (int i = 0; i < 60 && cnt_dout != 10'd40; i++) @(negedge clock);
        chk("reach_40", 32'(cnt_dout), 40);
        abort = 1'b1;
        #1 chk("abort_en_low", 32'(cnt_en), 0);
        @(negedge clock);
        chk("abort_done", {done, done_aborted}, 2'b11);
        chk("abort_id", 32'(done_id), 0);
        chk("abort_dout", 32'(cnt_dout), 40);
        abort = 1'b0;
        @(negedge clock);
        chk("abort_idle", {done, busy}, 0);
        chk("abort_hold", 32'(cnt_dout), 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
